// File: rtl/product_accumulator_if.sv
// Product-in / result-out bundle between the multiplier and the accumulator.
interface product_accumulator_if #(
    parameter int unsigned PROD_W = 8,
    parameter int unsigned ACC_W  = 12,
    parameter int unsigned CNT_W  = 4
);
    logic              start;
    logic [CNT_W-1:0]  num_terms;
    logic              prod_valid;
    logic [PROD_W-1:0] prod_data;
    logic              prod_ready;
    logic              acc_valid;
    logic [ACC_W-1:0]  acc_data;
    logic              acc_ready;
    logic              overflow;
    logic              busy;

    // Job source / result consumer side
    modport master (
        output start, num_terms, prod_valid, prod_data, acc_ready,
        input  prod_ready, acc_valid, acc_data, overflow, busy
    );

    // Accumulator side
    modport slave (
        input  start, num_terms, prod_valid, prod_data, acc_ready,
        output prod_ready, acc_valid, acc_data, overflow, busy
    );
endinterface

// File: rtl/product_accumulator.sv
// Sums a programmed number of multiplier products and holds the total until taken.
module product_accumulator #(
    parameter int unsigned PROD_W = 8,
    parameter int unsigned ACC_W  = 12,
    parameter int unsigned CNT_W  = 4
) (
    input  logic                 clk,
    input  logic                 rst,
    product_accumulator_if.slave bus
);
    // One extra bit catches the carry out of the accumulator.
    localparam int unsigned SUM_W = ACC_W + 1;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ACCUM = 2'd1,
        HOLD  = 2'd2
    } state_t;

    state_t            state_q;
    logic [ACC_W-1:0]  acc_q;
    logic [CNT_W-1:0]  remaining_q;
    logic              overflow_q;
    logic              prod_ready_q;
    logic              acc_valid_q;
    logic              busy_q;
    logic [SUM_W-1:0]  sum_c;

    // Widened add so the carry-out is visible for the sticky overflow flag.
    assign sum_c = {1'b0, acc_q} + SUM_W'(bus.prod_data);

    // Job FSM; handshake flags are registered alongside the state they decode.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q      <= IDLE;
            acc_q        <= '0;
            remaining_q  <= '0;
            overflow_q   <= 1'b0;
            prod_ready_q <= 1'b0;
            acc_valid_q  <= 1'b0;
            busy_q       <= 1'b0;
        end else begin
            case (state_q)
                IDLE: begin
                    if (bus.start) begin
                        acc_q       <= '0;
                        overflow_q  <= 1'b0;
                        remaining_q <= bus.num_terms;
                        busy_q      <= 1'b1;
                        if (bus.num_terms == '0) begin
                            state_q     <= HOLD;
                            acc_valid_q <= 1'b1;
                        end else begin
                            state_q      <= ACCUM;
                            prod_ready_q <= 1'b1;
                        end
                    end
                end
                ACCUM: begin
                    if (bus.prod_valid && prod_ready_q) begin
                        acc_q       <= sum_c[ACC_W-1:0];
                        overflow_q  <= overflow_q | sum_c[ACC_W];
                        remaining_q <= remaining_q - CNT_W'(1);
                        if (remaining_q == CNT_W'(1)) begin
                            state_q      <= HOLD;
                            prod_ready_q <= 1'b0;
                            acc_valid_q  <= 1'b1;
                        end
                    end
                end
                HOLD: begin
                    // A start in this cycle is dropped; the next job needs IDLE first.
                    if (bus.acc_ready) begin
                        state_q     <= IDLE;
                        acc_valid_q <= 1'b0;
                        busy_q      <= 1'b0;
                    end
                end
                default: begin
                    state_q      <= IDLE;
                    prod_ready_q <= 1'b0;
                    acc_valid_q  <= 1'b0;
                    busy_q       <= 1'b0;
                end
            endcase
        end
    end

    assign bus.prod_ready = prod_ready_q;
    assign bus.acc_valid  = acc_valid_q;
    assign bus.acc_data   = acc_q;
    assign bus.overflow   = overflow_q;
    assign bus.busy       = busy_q;

endmodule

// File: tb/tb_product_accumulator.sv
// Directed bench for product_accumulator: 12-bit and 10-bit accumulator instances.
module tb_product_accumulator;
    logic clk;
    logic rst;
    int   pass_cnt;
    int   total_cnt;

    product_accumulator_if #(.PROD_W(8), .ACC_W(12), .CNT_W(4)) ifa ();
    product_accumulator_if #(.PROD_W(8), .ACC_W(10), .CNT_W(4)) ifb ();

    product_accumulator #(.PROD_W(8), .ACC_W(12), .CNT_W(4)) dut (
        .clk (clk),
        .rst (rst),
        .bus (ifa)
    );

    product_accumulator #(.PROD_W(8), .ACC_W(10), .CNT_W(4)) dut10 (
        .clk (clk),
        .rst (rst),
        .bus (ifb)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Inputs change and outputs are observed at the falling edge.
    task automatic step();
        @(negedge clk);
    endtask

    task automatic start_a(input logic [3:0] n);
        ifa.start = 1'b1; ifa.num_terms = n;
        step();
        ifa.start = 1'b0;
    endtask

    task automatic send_a(input logic [7:0] p);
        ifa.prod_valid = 1'b1; ifa.prod_data = p;
        step();
        ifa.prod_valid = 1'b0;
    endtask

    task automatic accept_a();
        ifa.acc_ready = 1'b1;
        step();
        ifa.acc_ready = 1'b0;
    endtask

    task automatic start_b(input logic [3:0] n);
        ifb.start = 1'b1; ifb.num_terms = n;
        step();
        ifb.start = 1'b0;
    endtask

    task automatic send_b(input logic [7:0] p);
        ifb.prod_valid = 1'b1; ifb.prod_data = p;
        step();
        ifb.prod_valid = 1'b0;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        step(); step();
        rst = 1'b0;
        step();
        total_cnt++;
        if ({ifa.acc_valid, ifa.prod_ready, ifa.overflow, ifa.busy} !== 4'b0000)
            $display("FAIL reset_flags got %b want 0000",
                     {ifa.acc_valid, ifa.prod_ready, ifa.overflow, ifa.busy});
        else pass_cnt++;
        total_cnt++;
        if (ifa.acc_data !== 12'd0) $display("FAIL reset_acc got %0d want 0", ifa.acc_data);
        else pass_cnt++;
    endtask

    task automatic test_basic_sum();
        start_a(4'd4);
        total_cnt++;
        if ({ifa.prod_ready, ifa.busy, ifa.acc_valid} !== 3'b110)
            $display("FAIL basic_accum_flags got %b want 110",
                     {ifa.prod_ready, ifa.busy, ifa.acc_valid});
        else pass_cnt++;
        ifa.prod_valid = 1'b1; ifa.prod_data = 8'd225;
        step(); step(); step();
        total_cnt++;
        if (ifa.acc_valid !== 1'b0) $display("FAIL basic_early_valid got %b want 0", ifa.acc_valid);
        else pass_cnt++;
        step();
        ifa.prod_valid = 1'b0;
        total_cnt++;
        if ({ifa.acc_valid, ifa.prod_ready, ifa.overflow} !== 3'b100)
            $display("FAIL basic_hold_flags got %b want 100",
                     {ifa.acc_valid, ifa.prod_ready, ifa.overflow});
        else pass_cnt++;
        total_cnt++;
        if (ifa.acc_data !== 12'd900) $display("FAIL basic_sum got %0d want 900", ifa.acc_data);
        else pass_cnt++;
        accept_a();
        total_cnt++;
        if ({ifa.acc_valid, ifa.busy} !== 2'b00 || ifa.acc_data !== 12'd900)
            $display("FAIL basic_idle got v/b %b data %0d want 00 900",
                     {ifa.acc_valid, ifa.busy}, ifa.acc_data);
        else pass_cnt++;
    endtask

    task automatic test_input_gaps();
        logic [7:0] terms [3];
        terms[0] = 8'd10; terms[1] = 8'd20; terms[2] = 8'd30;
        start_a(4'd3);
        for (int i = 0; i < 3; i++) begin
            send_a(terms[i]);
            if (i < 2) begin
                for (int g = 0; g < 2; g++) begin
                    total_cnt++;
                    if (ifa.prod_ready !== 1'b1 || ifa.acc_valid !== 1'b0)
                        $display("FAIL gaps_ready term%0d gap%0d got r/v %b%b want 10",
                                 i, g, ifa.prod_ready, ifa.acc_valid);
                    else pass_cnt++;
                    step();
                end
            end
        end
        total_cnt++;
        if (ifa.acc_valid !== 1'b1 || ifa.acc_data !== 12'd60)
            $display("FAIL gaps_sum got v %b data %0d want 1 60", ifa.acc_valid, ifa.acc_data);
        else pass_cnt++;
        // A product offered during HOLD must not be absorbed.
        ifa.prod_valid = 1'b1; ifa.prod_data = 8'd99;
        step(); step();
        ifa.prod_valid = 1'b0;
        total_cnt++;
        if (ifa.prod_ready !== 1'b0 || ifa.acc_data !== 12'd60)
            $display("FAIL gaps_no_extra got r %b data %0d want 0 60", ifa.prod_ready, ifa.acc_data);
        else pass_cnt++;
        accept_a();
    endtask

    task automatic test_backpressure();
        start_a(4'd2);
        send_a(8'd7);
        send_a(8'd9);
        for (int c = 0; c < 5; c++) begin
            total_cnt++;
            if (ifa.acc_valid !== 1'b1 || ifa.acc_data !== 12'd16)
                $display("FAIL bp_hold cyc%0d got v %b data %0d want 1 16",
                         c, ifa.acc_valid, ifa.acc_data);
            else pass_cnt++;
            if (c == 2) begin
                ifa.start = 1'b1; ifa.num_terms = 4'd3;
            end
            step();
            ifa.start = 1'b0;
        end
        // Start coincident with the result handshake is dropped too.
        ifa.acc_ready = 1'b1; ifa.start = 1'b1; ifa.num_terms = 4'd1;
        step();
        ifa.acc_ready = 1'b0; ifa.start = 1'b0;
        total_cnt++;
        if ({ifa.acc_valid, ifa.busy, ifa.prod_ready} !== 3'b000 || ifa.acc_data !== 12'd16)
            $display("FAIL bp_release got flags %b data %0d want 000 16",
                     {ifa.acc_valid, ifa.busy, ifa.prod_ready}, ifa.acc_data);
        else pass_cnt++;
        step();
        total_cnt++;
        if (ifa.busy !== 1'b0) $display("FAIL bp_start_ignored got busy %b want 0", ifa.busy);
        else pass_cnt++;
    endtask

    task automatic test_full_scale();
        start_a(4'd15);
        ifa.prod_valid = 1'b1; ifa.prod_data = 8'd225;
        for (int i = 0; i < 15; i++) step();
        ifa.prod_valid = 1'b0;
        total_cnt++;
        if (ifa.acc_valid !== 1'b1 || ifa.acc_data !== 12'd3375 || ifa.overflow !== 1'b0)
            $display("FAIL full_scale got v %b data %0d ovf %b want 1 3375 0",
                     ifa.acc_valid, ifa.acc_data, ifa.overflow);
        else pass_cnt++;
        accept_a();
    endtask

    task automatic test_zero_terms();
        start_a(4'd0);
        total_cnt++;
        if ({ifa.acc_valid, ifa.prod_ready, ifa.overflow, ifa.busy} !== 4'b1001 ||
            ifa.acc_data !== 12'd0)
            $display("FAIL zero_terms got flags %b data %0d want 1001 0",
                     {ifa.acc_valid, ifa.prod_ready, ifa.overflow, ifa.busy}, ifa.acc_data);
        else pass_cnt++;
        accept_a();
    endtask

    task automatic test_reset_mid_job();
        start_a(4'd5);
        send_a(8'd100);
        send_a(8'd100);
        rst = 1'b1;
        step();
        rst = 1'b0;
        total_cnt++;
        if ({ifa.acc_valid, ifa.prod_ready, ifa.overflow, ifa.busy} !== 4'b0000 ||
            ifa.acc_data !== 12'd0)
            $display("FAIL reset_mid got flags %b data %0d want 0000 0",
                     {ifa.acc_valid, ifa.prod_ready, ifa.overflow, ifa.busy}, ifa.acc_data);
        else pass_cnt++;
        start_a(4'd1);
        send_a(8'd50);
        total_cnt++;
        if (ifa.acc_valid !== 1'b1 || ifa.acc_data !== 12'd50)
            $display("FAIL reset_fresh_job got v %b data %0d want 1 50", ifa.acc_valid, ifa.acc_data);
        else pass_cnt++;
        accept_a();
    endtask

    task automatic test_wrap_overflow();
        start_b(4'd5);
        for (int i = 0; i < 5; i++) send_b(8'd225);
        total_cnt++;
        if (ifb.acc_valid !== 1'b1 || ifb.acc_data !== 10'd101 || ifb.overflow !== 1'b1)
            $display("FAIL wrap_sum got v %b data %0d ovf %b want 1 101 1",
                     ifb.acc_valid, ifb.acc_data, ifb.overflow);
        else pass_cnt++;
        ifb.acc_ready = 1'b1;
        step();
        ifb.acc_ready = 1'b0;
        start_b(4'd1);
        send_b(8'd3);
        total_cnt++;
        if (ifb.acc_data !== 10'd3 || ifb.overflow !== 1'b0)
            $display("FAIL wrap_next_job got data %0d ovf %b want 3 0", ifb.acc_data, ifb.overflow);
        else pass_cnt++;
        ifb.acc_ready = 1'b1;
        step();
        ifb.acc_ready = 1'b0;
    endtask

    initial begin
        pass_cnt = 0;
        total_cnt = 0;
        rst = 1'b1;
        ifa.start = 1'b0; ifa.num_terms = '0; ifa.prod_valid = 1'b0;
        ifa.prod_data = '0; ifa.acc_ready = 1'b0;
        ifb.start = 1'b0; ifb.num_terms = '0; ifb.prod_valid = 1'b0;
        ifb.prod_data = '0; ifb.acc_ready = 1'b0;
        test_reset();
        test_basic_sum();
        test_input_gaps();
        test_backpressure();
        test_full_scale();
        test_zero_terms();
        test_reset_mid_job();
        test_wrap_overflow();
        $display("%0d/%0d checks passed", pass_cnt, total_cnt);
        $finish;
    end
endmodule

// File: doc/product_accumulator.md
Name: product_accumulator

Overview:
Downstream stage for the 4x4 array multiplier. It consumes the 8-bit products over a valid/ready handshake and sums a programmed number of them (a dot-product / MAC reduction). It then presents the total on a held result interface until that result is accepted. All arithmetic is registered; the multiplier in front of it stays purely combinational.

Parameters:
PROD_W, 8, product width; matches the multiplier output Z[7:0]
ACC_W, 12, accumulator width; 12 covers 15 x 225 = 3375 with no wrap
CNT_W, 4, width of the term count; jobs of 0..15 terms

Ports:
clk  input  1  single clock, rising edge
rst  input  1  synchronous, active-high reset
start  input  1  one-cycle job start; honoured only in IDLE
num_terms  input  CNT_W  number of products in the job; sampled on accepted start
prod_valid  input  1  prod_data is valid
prod_data  input  PROD_W  product from the multiplier
prod_ready  output  1  block accepts a product this cycle
acc_valid  output  1  result available
acc_data  output  ACC_W  accumulated sum
acc_ready  input  1  consumer accepts the result
overflow  output  1  sticky flag: at least one carry out of ACC_W during this job
busy  output  1  high in ACCUM and HOLD

Behaviour:
- One clock domain. Reset is synchronous and active-high.
- Reset (applies on any cycle, mid-job included):
  - state goes to IDLE;
  - acc_data, acc_valid, prod_ready, overflow and busy are all 0;
  - the internal remaining count is 0;
  - any partial job is discarded.
- FSM states: IDLE, ACCUM, HOLD.
- IDLE:
  - prod_ready=0, acc_valid=0, busy=0.
  - On start=1: acc is cleared, overflow is cleared, and remaining is loaded with num_terms.
  - If num_terms=0, go to HOLD with acc=0; otherwise go to ACCUM.
- ACCUM:
  - prod_ready=1 combinationally from the state, with no dependency on prod_valid.
  - A transfer occurs when prod_valid and prod_ready are both 1. On a transfer:
    - acc <= acc + zero-extended prod_data, modulo 2^ACC_W;
    - overflow <= overflow OR carry-out;
    - remaining decrements.
  - On a transfer with remaining=1, go to HOLD.
  - Cycles with prod_valid=0 leave everything unchanged; there is no timeout.
- HOLD:
  - acc_valid=1, prod_ready=0.
  - acc_data and overflow stay stable until acc_ready=1.
  - On acc_ready=1, go to IDLE; acc_valid drops the next cycle.
- Latency: acc_valid rises the cycle after the last product transfer. Throughput is at most one product per cycle.
- start outside IDLE is ignored and has no effect on count or acc. A start in the same cycle as the HOLD handshake is also ignored; the next job starts from IDLE one cycle later.
- acc_data keeps its last value in IDLE; it is not cleared until the next accepted start.
- Product width: prod_data is unsigned and zero-extended. PROD_W <= ACC_W is required.

Test Plan:
- Basic sum: start with num_terms=4, then products 225,225,225,225 back-to-back with valid held high -> acc_valid rises one cycle after the 4th transfer; acc_data=900 (0x384), overflow=0.
- Input gaps: num_terms=3, products 10,20,30 with 2 idle cycles between each -> acc_data=60. prod_ready stays 1 throughout ACCUM; no extra terms are absorbed.
- Output backpressure: after a job of 2 terms (7,9), hold acc_ready=0 for 5 cycles -> acc_data=16 and acc_valid=1 stable for all 5 cycles. Pulse start during HOLD -> ignored. On acc_ready=1 -> IDLE next cycle.
- Wrap and overflow: with ACC_W=10, num_terms=5, products 225 x5 -> acc_data=1125-1024=101, overflow=1. The next job (num_terms=1, product 3) -> acc_data=3, overflow=0.
- Zero terms: start with num_terms=0 -> acc_valid=1 the next cycle, acc_data=0, overflow=0, prod_ready never asserts.
- Reset mid-job: num_terms=5, transfer 2 products, assert rst for 1 cycle -> all outputs 0 and state IDLE. A fresh job (num_terms=1, product 50) then gives acc_data=50.
